// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding for the cache controller FSM
//   Exports state_t (logic [3:0]) used by cache_controller and its benches.

package cache_pkg;

  typedef enum logic [3:0] {
    IDLE           = 4'd0,
    COMPARE        = 4'd1,
    WRITE_BACK     = 4'd2,
    WRITE_ALLOCATE = 4'd3,
    REFILL_DONE    = 4'd4
  } state_t;

endpackage

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - write-back/write-allocate cache request sequencer
//   Inputs : clk, rst (async, active-high), req_valid, req_type (0 rd / 1 wr),
//            hit, dirty_bit, ready_mem
//   Outputs: read_en_mem, write_en_mem, write_en, read_en_cache,
//            write_en_cache (combinational strobes),
//            refill, done_cache (registered one-cycle pulses)

module cache_controller
  import cache_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_type,
  input  logic hit,
  input  logic dirty_bit,
  input  logic ready_mem,
  output logic read_en_mem,
  output logic write_en_mem,
  output logic write_en,
  output logic read_en_cache,
  output logic write_en_cache,
  output logic refill,
  output logic done_cache
);

  state_t current_state;
  state_t w_next_state;
  logic   w_set_refill;
  logic   w_set_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      current_state <= IDLE;
    end else begin
      current_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = current_state;
    read_en_mem    = 1'b0;
    write_en_mem   = 1'b0;
    write_en       = 1'b0;
    read_en_cache  = 1'b0;
    write_en_cache = 1'b0;
    w_set_refill   = 1'b0;
    w_set_done     = 1'b0;
    case (current_state)
      IDLE: begin
        if (req_valid) w_next_state = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          write_en      = req_type;
          read_en_cache = ~req_type;
          w_set_done    = 1'b1;
          w_next_state  = IDLE;
        end else if (dirty_bit) begin
          write_en_mem = 1'b1;
          w_next_state = WRITE_BACK;
        end else begin
          read_en_mem  = 1'b1;
          w_next_state = WRITE_ALLOCATE;
        end
      end
      WRITE_BACK: begin
        write_en_mem = 1'b1;
        if (ready_mem) w_next_state = WRITE_ALLOCATE;
      end
      WRITE_ALLOCATE: begin
        // Keep the read request up through the cycle memory reports completion.
        read_en_mem = 1'b1;
        if (ready_mem) w_next_state = REFILL_DONE;
      end
      REFILL_DONE: begin
        // Line is now resident; re-run the lookup, which is expected to hit.
        write_en_cache = 1'b1;
        w_set_refill   = 1'b1;
        w_next_state   = COMPARE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Pulses are rewritten every cycle, so they last exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refill     <= 1'b0;
      done_cache <= 1'b0;
    end else begin
      refill     <= w_set_refill;
      done_cache <= w_set_done;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - self-checking bench for cache_controller

module tb_cache_controller;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_type, hit, dirty_bit, ready_mem;
  logic read_en_mem, write_en_mem, write_en, read_en_cache, write_en_cache;
  logic refill, done_cache;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_type       (req_type),
    .hit            (hit),
    .dirty_bit      (dirty_bit),
    .ready_mem      (ready_mem),
    .read_en_mem    (read_en_mem),
    .write_en_mem   (write_en_mem),
    .write_en       (write_en),
    .read_en_cache  (read_en_cache),
    .write_en_cache (write_en_cache),
    .refill         (refill),
    .done_cache     (done_cache)
  );

  // One cycle of stimulus plus the observation expected for that cycle.
  typedef struct packed {
    logic        rv;
    logic        rt;
    logic        h;
    logic        d;
    logic        rdy;
    logic [10:0] exp;
  } cyc_t;

  cyc_t q[$];

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // {state, read_en_mem, write_en_mem, write_en, read_en_cache, write_en_cache, refill, done_cache}
  function automatic logic [10:0] ex(state_t s, logic rem, logic wem, logic we,
                                     logic rec, logic wec, logic rf, logic dn);
    return {s, rem, wem, we, rec, wec, rf, dn};
  endfunction

  function automatic logic [10:0] obs();
    return {dut.current_state, read_en_mem, write_en_mem, write_en, read_en_cache,
            write_en_cache, refill, done_cache};
  endfunction

  function automatic void push(logic rv, logic rt, logic h, logic d, logic rdy, logic [10:0] e);
    cyc_t c;
    c.rv = rv; c.rt = rt; c.h = h; c.d = d; c.rdy = rdy; c.exp = e;
    q.push_back(c);
  endfunction

  task automatic chk(input string tag, input logic [10:0] o, input logic [10:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Expected trace for one whole request, derived from the request's
  // transaction-level description (type, hit, dirty, memory wait lengths).
  task automatic gen_req(input logic t, input logic h, input logic d, input int nwb, input int nwa);
    push(1'b1, t, rb(), rb(), rb(), ex(IDLE, 0, 0, 0, 0, 0, 0, 0));
    if (h) begin
      push(1'b1, t, 1'b1, rb(), rb(), ex(COMPARE, 0, 0, t, !t, 0, 0, 0));
    end else begin
      push(1'b1, t, 1'b0, d, rb(), ex(COMPARE, !d, d, 0, 0, 0, 0, 0));
      if (d) begin
        repeat (nwb) push(1'b1, t, rb(), rb(), 1'b0, ex(WRITE_BACK, 0, 1, 0, 0, 0, 0, 0));
        push(1'b1, t, rb(), rb(), 1'b1, ex(WRITE_BACK, 0, 1, 0, 0, 0, 0, 0));
      end
      repeat (nwa) push(1'b1, t, rb(), rb(), 1'b0, ex(WRITE_ALLOCATE, 1, 0, 0, 0, 0, 0, 0));
      push(1'b1, t, rb(), rb(), 1'b1, ex(WRITE_ALLOCATE, 1, 0, 0, 0, 0, 0, 0));
      push(1'b1, t, rb(), rb(), rb(), ex(REFILL_DONE, 0, 0, 0, 0, 1, 0, 0));
      push(1'b1, t, 1'b1, rb(), rb(), ex(COMPARE, 0, 0, t, !t, 0, 1, 0));
    end
    push(1'b0, rb(), rb(), rb(), rb(), ex(IDLE, 0, 0, 0, 0, 0, 0, 1));
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic drain(input string tag);
    int n = 0;
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(posedge clk);
      #1;
      req_valid = c.rv; req_type = c.rt; hit = c.h; dirty_bit = c.d; ready_mem = c.rdy;
      @(negedge clk);
      chk($sformatf("%s_c%0d", tag, n), obs(), c.exp);
      n++;
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b1; req_type = 1'b0; hit = 1'b1; dirty_bit = 1'b1; ready_mem = 1'b1;
    @(negedge clk);
    chk("reset_hold", obs(), ex(IDLE, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("reset_hold2", obs(), ex(IDLE, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("reset_release", obs(), ex(IDLE, 0, 0, 0, 0, 0, 0, 0));

    gen_req(1'b0, 1'b0, 1'b0, 1, 1); drain("rd_miss_clean");
    gen_req(1'b0, 1'b0, 1'b1, 3, 0); drain("rd_miss_dirty");
    gen_req(1'b1, 1'b1, 1'b0, 0, 0); drain("wr_hit");
    gen_req(1'b0, 1'b1, 1'b1, 0, 0); drain("rd_hit");
    gen_req(1'b1, 1'b0, 1'b1, 0, 0); drain("wr_miss_dirty_fast");

    // Reset while waiting in WRITE_ALLOCATE.
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(IDLE, 0, 0, 0, 0, 0, 0, 0));
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(COMPARE, 1, 0, 0, 0, 0, 0, 0));
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(WRITE_ALLOCATE, 1, 0, 0, 0, 0, 0, 0));
    drain("pre_reset");
    #1;
    rst = 1'b1;
    #1;
    chk("mid_reset", obs(), ex(IDLE, 0, 0, 0, 0, 0, 0, 0));
    #1;
    rst = 1'b0; req_valid = 1'b0; ready_mem = 1'b1;
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(IDLE, 0, 0, 0, 0, 0, 0, 0));
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(IDLE, 0, 0, 0, 0, 0, 0, 0));
    drain("post_reset");

    // Back-to-back: req_valid still high during the done_cache cycle.
    push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ex(IDLE, 0, 0, 0, 0, 0, 0, 0));
    push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ex(COMPARE, 0, 0, 0, 1, 0, 0, 0));
    push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ex(IDLE, 0, 0, 0, 0, 0, 0, 1));
    push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ex(COMPARE, 0, 0, 0, 1, 0, 0, 0));
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(IDLE, 0, 0, 0, 0, 0, 0, 1));
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(IDLE, 0, 0, 0, 0, 0, 0, 0));
    drain("back2back");

    for (int i = 0; i < 40; i++) begin
      gen_req(rb(), rb(), rb(), $urandom_range(0, 3), $urandom_range(0, 3));
      drain($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Cache controller FSM sequencing a single CPU request against a write-back, write-allocate cache. It sits between the CPU request interface, the cache tag/data arrays (which supply `hit` and `dirty_bit`) and the next-level memory handshake (`ready_mem`). It issues the enable strobes that drive cache lookups, dirty-line write-back, line refill and request completion.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: CPU request pending; sampled only in IDLE.
- `req_type` in 1: 0 = read, 1 = write.
- `hit` in 1: tag match for the current request address.
- `dirty_bit` in 1: victim line is dirty.
- `ready_mem` in 1: memory has completed the current read or write transfer.
- `read_en_mem` out 1: memory line read request.
- `write_en_mem` out 1: memory write-back of the victim line.
- `write_en` out 1: CPU write data into the cache on a write hit.
- `read_en_cache` out 1: cache read for a read hit.
- `write_en_cache` out 1: write the refilled line into the cache arrays.
- `refill` out 1: registered one-cycle pulse; refill completed.
- `done_cache` out 1: registered one-cycle pulse; request completed.

## Operation
- States are held in a 4-bit `state_t` register named `current_state`: IDLE=0, COMPARE=1, WRITE_BACK=2, WRITE_ALLOCATE=3, REFILL_DONE=4.
- **IDLE:** no strobes. If `req_valid` is 1, go to COMPARE; otherwise stay in IDLE.
- **COMPARE, hit:**
  - read asserts `read_en_cache`; write asserts `write_en`.
  - Next state is IDLE, and `done_cache` is set for the following cycle.
- **COMPARE, miss:**
  - If `dirty_bit` is 1: assert `write_en_mem` and go to WRITE_BACK.
  - If `dirty_bit` is 0: assert `read_en_mem` and go to WRITE_ALLOCATE.
- **WRITE_BACK:** `write_en_mem` is 1. If `ready_mem` is 1, go to WRITE_ALLOCATE; otherwise stay.
- **WRITE_ALLOCATE:** `read_en_mem` is 1, including in the cycle where `ready_mem` is 1. If `ready_mem` is 1, go to REFILL_DONE; otherwise stay.
- **REFILL_DONE:** `write_en_cache` is 1. Go to COMPARE unconditionally, and `refill` is set for the following cycle. The request is then re-evaluated and hits.
- Strobe outputs are combinational from `current_state` plus inputs. `refill` and `done_cache` are flops, each cleared every cycle unless set by the rule above.
- Unlisted or illegal state encodings go to IDLE with all strobes at 0.
- `req_valid`, `req_type` and the address are held stable by the requester until `done_cache`.

## Timing
- **Reset:**
  - Reset asserted at any time, including mid-refill or mid-write-back, forces IDLE immediately.
  - `refill` and `done_cache` are 0 and all combinational strobes are 0 while in reset.
  - Any outstanding memory transfer is abandoned.
- **Read hit:** request accepted in cycle N, COMPARE in N+1 with `read_en_cache`, `done_cache`=1 in N+2 with the FSM back in IDLE.
- **Clean miss:**
  - COMPARE (`read_en_mem`), then WRITE_ALLOCATE until `ready_mem`, then REFILL_DONE (`write_en_cache`=1, `refill`=0).
  - Then COMPARE (`refill`=1), then IDLE (`done_cache`=1).
- **Dirty miss:** the clean-miss sequence with WRITE_BACK inserted; WRITE_BACK lasts at least 1 cycle.
- `ready_mem` is only sampled in WRITE_BACK and WRITE_ALLOCATE. A `ready_mem` that is already high on entry advances the FSM after one cycle.
- `req_valid` held high in IDLE after `done_cache` starts a new request the next cycle.

## Structure
- Shared package `cache_pkg` holds the `state_t` enum (logic [3:0], encodings above). Benches import it rather than redeclaring it.
- Single module with no sub-modules. It has a state register block, next-state/strobe combinational logic, and a registered pulse block for `refill` and `done_cache`.

## Test plan
- **Reset:** `rst`=1, then 0 → `current_state`=IDLE, all outputs 0.
- **Read miss clean:**
  - `req_valid`=1, `req_type`=0, `hit`=0, `dirty_bit`=0 → COMPARE with `read_en_mem`=1.
  - `ready_mem`=0 → WRITE_ALLOCATE, `read_en_mem`=1.
  - `ready_mem`=1 → REFILL_DONE, `write_en_cache`=1, `refill`=0.
  - → COMPARE, `refill`=1.
  - `hit`=1 → IDLE, `done_cache`=1; next cycle stays IDLE.
- **Read miss dirty:** `dirty_bit`=1 → `write_en_mem`=1 in COMPARE and WRITE_BACK for 3 cycles of `ready_mem`=0. Then `ready_mem`=1 → WRITE_ALLOCATE, then the clean-miss sequence follows.
- **Write hit:** `req_type`=1, `hit`=1 → COMPARE `write_en`=1, `read_en_cache`=0, then IDLE with `done_cache`=1.
- **Reset mid-operation:** `rst` pulsed while in WRITE_ALLOCATE → IDLE immediately, `read_en_mem`=0, no `refill` pulse.
- **Back-to-back:** `req_valid` held 1 after a read hit → COMPARE re-entered the cycle after `done_cache`.
